// File: rtl/instruction_decode_stage.sv
// Decode stage: combinational field/immediate/target decode feeding a DEPTH-entry
// output FIFO with valid/ready handshakes and a saturating illegal-instruction counter.
module instruction_decode_stage #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int ZEXT_LOGIC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_baddr,
  output logic [XLEN-1:0] out_jaddr,
  output logic [1:0]      out_type,
  output logic [4:0]      out_wreg,
  output logic [15:0]     illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] baddr;
    logic [XLEN-1:0] jaddr;
    logic [1:0]      itype;
    logic [4:0]      wreg;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          shown;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [15:0]     imm16;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] imm_sext;

  always_comb begin
    imm16    = in_instr[15:0];
    pc4      = in_pc + XLEN'(4);
    imm_sext = {XLEN{imm16[15]}};
    imm_sext[15:0] = imm16;

    dec        = '0;
    dec.opcode = in_instr[31:26];
    dec.rs     = in_instr[25:21];
    dec.rt     = in_instr[20:16];
    dec.rd     = in_instr[15:11];
    dec.shamt  = in_instr[10:6];
    dec.funct  = in_instr[5:0];
    dec.pc     = in_pc;

    if (dec.opcode == 6'h00)
      dec.itype = 2'b00;
    else if (dec.opcode inside {6'h02, 6'h03})
      dec.itype = 2'b10;
    else if (dec.opcode inside {6'h01, [6'h04:6'h0F], [6'h20:6'h26], [6'h28:6'h2B]})
      dec.itype = 2'b01;
    else
      dec.itype = 2'b11;

    // lui places imm16 in bits 31:16 and sign-extends from bit 31 for wider XLEN
    if (dec.opcode == 6'h0F) begin
      dec.imm = {XLEN{imm16[15]}};
      dec.imm[31:0] = {imm16, 16'h0000};
    end else if (ZEXT_LOGIC != 0 && dec.opcode inside {[6'h0C:6'h0E]}) begin
      dec.imm = XLEN'(imm16);
    end else begin
      dec.imm = imm_sext;
    end

    dec.baddr = pc4 + (imm_sext << 2);
    dec.jaddr = pc4;
    dec.jaddr[27:0] = {in_instr[25:0], 2'b00};

    if (dec.opcode == 6'h00)
      dec.wreg = dec.rd;
    else if (dec.opcode inside {[6'h08:6'h0F], [6'h20:6'h26]})
      dec.wreg = dec.rt;
    else if (dec.opcode == 6'h03)
      dec.wreg = 5'd31;
    else
      dec.wreg = 5'd0;
  end

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Counting is independent of flush: an illegal accept in a flush cycle still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= '0;
    else if (push && dec.itype == 2'b11 && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end

  // Storage is not reset; gating on out_valid keeps data fields at zero when empty
  assign head  = mem[rd_ptr];
  assign shown = out_valid ? head : '0;

  assign out_opcode = shown.opcode;
  assign out_rs     = shown.rs;
  assign out_rt     = shown.rt;
  assign out_rd     = shown.rd;
  assign out_shamt  = shown.shamt;
  assign out_funct  = shown.funct;
  assign out_pc     = shown.pc;
  assign out_imm    = shown.imm;
  assign out_baddr  = shown.baddr;
  assign out_jaddr  = shown.jaddr;
  assign out_type   = shown.itype;
  assign out_wreg   = shown.wreg;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed and randomized checks of instruction_decode_stage against an arithmetic
// reference model holding expected entries in a queue.
module tb_instruction_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_baddr;
  logic [XLEN-1:0] out_jaddr;
  logic [1:0]      out_type;
  logic [4:0]      out_wreg;
  logic [15:0]     illegal_cnt;

  instruction_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .ZEXT_LOGIC(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_pc(out_pc), .out_imm(out_imm),
    .out_baddr(out_baddr), .out_jaddr(out_jaddr), .out_type(out_type),
    .out_wreg(out_wreg), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] pc, imm, ba, ja;
    logic [1:0]  ty;
    logic [4:0]  wr;
  } ent_t;

  ent_t q[$];
  int   m_ill = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected entry from the instruction-set rules, using plain integer arithmetic
  function automatic ent_t mk(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    longint li, op, imm16, s, v, pc4, rt, rd;
    li    = longint'(ins);
    op    = li / (2 ** 26);
    imm16 = li % 65536;
    rt    = (li / (2 ** 16)) % 32;
    rd    = (li / (2 ** 11)) % 32;
    s     = (imm16 >= 32768) ? imm16 - 65536 : imm16;
    e.opc = 6'(op);
    e.rs  = 5'((li / (2 ** 21)) % 32);
    e.rt  = 5'(rt);
    e.rd  = 5'(rd);
    e.sh  = 5'((li / 64) % 32);
    e.fn  = 6'(li % 64);
    e.pc  = pc;
    if (op == 0) e.ty = 2'd0;
    else if (op == 2 || op == 3) e.ty = 2'd2;
    else if (op == 1 || (op >= 4 && op <= 15) || (op >= 32 && op <= 38) || (op >= 40 && op <= 43))
      e.ty = 2'd1;
    else e.ty = 2'd3;
    if (op == 15) v = s * 65536;
    else if (op >= 12 && op <= 14) v = imm16;
    else v = s;
    e.imm = 32'(v);
    pc4   = longint'(pc) + 4;
    e.ba  = 32'(pc4 + s * 4);
    e.ja  = 32'((pc4 / (2 ** 28)) * (2 ** 28) + (li % (2 ** 26)) * 4);
    if (op == 0) e.wr = 5'(rd);
    else if ((op >= 8 && op <= 15) || (op >= 32 && op <= 38)) e.wr = 5'(rt);
    else if (op == 3) e.wr = 5'd31;
    else e.wr = 5'd0;
    return e;
  endfunction

  task automatic check_state();
    chk("in_ready", in_ready, (q.size() < DEPTH));
    chk("out_valid", out_valid, (q.size() > 0));
    chk("illegal_cnt", illegal_cnt, m_ill);
    if (q.size() > 0) begin
      chk("opcode", out_opcode, q[0].opc);
      chk("rs", out_rs, q[0].rs);
      chk("rt", out_rt, q[0].rt);
      chk("rd", out_rd, q[0].rd);
      chk("shamt", out_shamt, q[0].sh);
      chk("funct", out_funct, q[0].fn);
      chk("pc", out_pc, q[0].pc);
      chk("imm", out_imm, q[0].imm);
      chk("baddr", out_baddr, q[0].ba);
      chk("jaddr", out_jaddr, q[0].ja);
      chk("type", out_type, q[0].ty);
      chk("wreg", out_wreg, q[0].wr);
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, output bit acc);
    ent_t e;
    bit   pp;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_state();
    e   = mk(ins, pc);
    acc = v && (q.size() < DEPTH);
    pp  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (acc && e.ty == 2'd3 && m_ill < 65535) m_ill++;
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  initial begin
    bit acc;
    int tries;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_illegal", illegal_cnt, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed decode of the reference instructions
    cycle(1, 32'h012A4020, 32'h00400000, 1, 0, acc);
    #1;
    chk("add_valid", out_valid, 1);
    chk("add_type", out_type, 0);
    chk("add_rs", out_rs, 9);
    chk("add_rt", out_rt, 10);
    chk("add_rd", out_rd, 8);
    chk("add_wreg", out_wreg, 8);
    chk("add_funct", out_funct, 6'h20);
    cycle(1, 32'h2108FFFF, 32'h00400010, 1, 0, acc);
    #1;
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_baddr", out_baddr, 32'h00400010);
    chk("addi_wreg", out_wreg, 8);
    cycle(1, 32'h3108FFFF, 32'h00400014, 1, 0, acc);
    #1;
    chk("andi_imm", out_imm, 32'h0000FFFF);
    cycle(1, 32'h0C100004, 32'h10000000, 1, 0, acc);
    #1;
    chk("jal_type", out_type, 2);
    chk("jal_jaddr", out_jaddr, 32'h10400010);
    chk("jal_wreg", out_wreg, 31);
    cycle(1, 32'h3C0A8001, 32'h00400020, 1, 0, acc);
    cycle(0, 32'h0, 32'h0, 1, 0, acc);
    cycle(0, 32'h0, 32'h0, 1, 0, acc);

    // Backpressure: two accepts fill the FIFO, the third is held until space frees
    cycle(1, 32'h8D090004, 32'h00401000, 0, 0, acc);
    cycle(1, 32'hAD090008, 32'h00401004, 0, 0, acc);
    cycle(1, 32'h1109FFFE, 32'h00401008, 0, 0, acc);
    chk("full_third_held", acc, 0);
    #1;
    chk("full_in_ready", in_ready, 0);
    tries = 0;
    do begin
      cycle(1, 32'h1109FFFE, 32'h00401008, 1, 0, acc);
      tries++;
    end while (!acc && tries < 10);
    chk("full_third_accepted", acc, 1);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0, acc);

    // Asynchronous reset between edges with entries buffered
    cycle(1, 32'hFC000000, 32'h00402000, 0, 0, acc);
    cycle(1, 32'h00851020, 32'h00402004, 0, 0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_illegal", illegal_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_baddr", out_baddr, 0);
    q.delete();
    m_ill = 0;
    @(negedge clk);
    rst = 1'b0;

    // Illegal opcodes and flush with a pending push
    cycle(1, 32'hFC123456, 32'h00403000, 0, 0, acc);
    cycle(1, 32'hFFFFFFFF, 32'h00403004, 0, 0, acc);
    #1;
    chk("ill_cnt", illegal_cnt, 2);
    chk("ill_type", out_type, 3);
    chk("ill_wreg", out_wreg, 0);
    cycle(1, 32'h012A4020, 32'h00403008, 0, 1, acc);
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    cycle(1, 32'h00000000, 32'h00403010, 0, 0, acc);
    cycle(1, 32'hE0000000, 32'h00403014, 0, 1, acc);
    #1;
    chk("flush_ill_cnt", illegal_cnt, 3);
    chk("flush2_out_valid", out_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      cycle(($urandom_range(0, 3) != 0), ins, $urandom(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0), acc);
    end
    cycle(0, 32'h0, 32'h0, 1, 0, acc);
    cycle(0, 32'h0, 32'h0, 1, 0, acc);
    cycle(0, 32'h0, 32'h0, 1, 0, acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/immediate/address width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; power of two, >=2.
REQ-003 SHALL have parameter ZEXT_LOGIC, default 1, 1 = zero-extend immediate for opcodes 0x0C/0x0D/0x0E.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  in  1  synchronous discard of all buffered entries.
REQ-007 SHALL have ports in_valid in 1, in_ready out 1, in_instr in 32, in_pc in XLEN: upstream handshake.
REQ-008 SHALL have ports out_valid out 1, out_ready in 1: downstream handshake.
REQ-009 SHALL have outputs out_opcode 6, out_rs 5, out_rt 5, out_rd 5, out_shamt 5, out_funct 6: raw fields [31:26],[25:21],[20:16],[15:11],[10:6],[5:0].
REQ-010 SHALL have outputs out_pc XLEN, out_imm XLEN, out_baddr XLEN, out_jaddr XLEN, out_type 2, out_wreg 5: decoded entry.
REQ-011 SHALL have output illegal_cnt 16: saturating count of illegal instructions accepted.

Function
REQ-012 SHALL decode in_instr combinationally and write the full decoded entry into a DEPTH-entry FIFO on each accept (in_valid && in_ready).
REQ-013 SHALL drive in_ready = (occupancy < DEPTH) from registered state only; no same-cycle pass-through when full.
REQ-014 SHALL drive out_valid = (occupancy > 0); out_* fields SHALL show the head entry and stay stable while out_valid && !out_ready.
REQ-015 SHALL pop the head on out_valid && out_ready; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-016 SHALL wrap read/write pointers modulo DEPTH.
REQ-017 SHALL classify out_type: 00 R (opcode 0x00); 10 J (0x02, 0x03); 01 I (0x01, 0x04-0x0F, 0x20-0x26, 0x28-0x2B); 11 illegal otherwise.
REQ-018 SHALL compute out_imm: {imm16,16'b0} sign-extended to XLEN for 0x0F; zero-extended imm16 for 0x0C-0x0E when ZEXT_LOGIC=1; sign-extended imm16 otherwise.
REQ-019 SHALL compute pc4 = in_pc + 4 mod 2^XLEN; out_baddr = pc4 + (sext(imm16) << 2) mod 2^XLEN; out_jaddr = {pc4[XLEN-1:28], instr[25:0], 2'b00}.
REQ-020 SHALL compute out_wreg: rd for R; rt for 0x08-0x0F and 0x20-0x26; 31 for 0x03; 0 otherwise (incl. illegal).
REQ-021 SHALL increment illegal_cnt on each accepted type-11 instruction, saturating at 0xFFFF.
REQ-022 SHALL, on flush, set occupancy and pointers to 0 at the next edge; a push or pop in the flush cycle SHALL be discarded; illegal_cnt SHALL still count an illegal accept in that cycle.
REQ-023 SHALL give latency of exactly one cycle from accept into an empty FIFO to out_valid.

Reset
REQ-024 SHALL, on rst assertion, immediately clear occupancy, pointers and illegal_cnt regardless of clk, including mid-handshake.
REQ-025 SHALL hold in_ready=1, out_valid=0, illegal_cnt=0 while rst is high; out_* data fields SHALL read 0.
REQ-026 SHALL resume accepting on the first rising edge after rst deasserts.

Verification
REQ-027 SHALL cover: accept 0x012A4020 (add $8,$9,$10), pc 0x00400000 -> next cycle out_type=00, out_rs=9, out_rt=10, out_rd=8, out_wreg=8, out_funct=0x20.
REQ-028 SHALL cover: 0x2108FFFF (addi $8,$8,-1), pc 0x00400010 -> out_imm=0xFFFFFFFF, out_baddr=0x00400010, out_wreg=8; 0x3108FFFF (andi) -> out_imm=0x0000FFFF.
REQ-029 SHALL cover: 0x0C100004 (jal), pc 0x10000000 -> out_type=10, out_jaddr=0x10400010, out_wreg=31.
REQ-030 SHALL cover: out_ready=0, push 3 entries with DEPTH=2 -> in_ready=0 after 2 accepts, third held; release out_ready -> entries emerge in order, none lost or duplicated.
REQ-031 SHALL cover: opcode 0x3F accepted twice -> out_type=11, out_wreg=0, illegal_cnt=2; flush with 2 entries and push pending -> out_valid=0 next cycle.
REQ-032 SHALL cover: rst asserted between edges with entries buffered -> out_valid=0, illegal_cnt=0 immediately, before next clk edge.
